// File: rtl/time_parameters.sv
// Programmable traffic-light interval store: three WIDTH-bit intervals (base, extended, yellow),
// rewritten one at a time by a synchronised strobe and read combinationally by address.
module time_parameters #(
    parameter int             WIDTH    = 4,
    parameter logic [WIDTH-1:0] DEF_BASE = 4'd6,
    parameter logic [WIDTH-1:0] DEF_EXT  = 4'd3,
    parameter logic [WIDTH-1:0] DEF_YEL  = 4'd2
) (
    input  logic             clk,
    input  logic             sys_reset,
    input  logic [1:0]       selector,
    input  logic [WIDTH-1:0] reprogram_value,
    input  logic             prg_sync_in,
    input  logic [1:0]       interval_address,
    output logic [WIDTH-1:0] output_value
);

    localparam int NUM_INT = 3;

    logic [NUM_INT-1:0][WIDTH-1:0] param;
    logic                          wr_ok;

    // A zero interval would stall the timer, so it is never committed.
    assign wr_ok = prg_sync_in && (selector != 2'd3) && (reprogram_value != '0);

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            param[0] <= DEF_BASE;
            param[1] <= DEF_EXT;
            param[2] <= DEF_YEL;
        end else if (wr_ok) begin
            param[selector] <= reprogram_value;
        end
    end

    // Address 11 aliases to the base interval.
    always_comb begin
        output_value = param[0];
        case (interval_address)
            2'd1:    output_value = param[1];
            2'd2:    output_value = param[2];
            default: output_value = param[0];
        endcase
    end

endmodule

// File: tb/tb_time_parameters.sv
// Directed bench for time_parameters: array-based interval model checked every cycle,
// plus literal expectations for each scenario.
module tb_time_parameters;

    logic       clk = 1'b0;
    logic       sys_reset = 1'b0;
    logic [1:0] selector = 2'd3;
    logic [3:0] reprogram_value = 4'd0;
    logic       prg_sync_in = 1'b0;
    logic [1:0] interval_address = 2'd0;
    logic [3:0] output_value;

    int n_checks = 0;
    int n_fail   = 0;
    bit live     = 1'b0;
    int model[3] = '{6, 3, 2};

    time_parameters dut (
        .clk              (clk),
        .sys_reset        (sys_reset),
        .selector         (selector),
        .reprogram_value  (reprogram_value),
        .prg_sync_in      (prg_sync_in),
        .interval_address (interval_address),
        .output_value     (output_value)
    );

    always #5 clk = ~clk;

    // Reference: reset restores defaults; a strobe writes a nonzero value to a real interval.
    always @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) model = '{6, 3, 2};
        else if (prg_sync_in && selector != 2'd3 && reprogram_value != 4'd0)
            model[selector] = int'(reprogram_value);
    end

    function automatic int expect_at(logic [1:0] a);
        return (a == 2'd3) ? model[0] : model[a];
    endfunction

    task automatic check(string name, logic [3:0] act, int exp);
        n_checks++;
        if (act !== 4'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) check("model", output_value, expect_at(interval_address));
    end

    task automatic rd(logic [1:0] a, int exp, string name);
        @(negedge clk); #1;
        interval_address = a;
        #1 check(name, output_value, exp);
    endtask

    task automatic wr(logic [1:0] sel, logic [3:0] val, int cycles);
        @(negedge clk); #1;
        selector = sel; reprogram_value = val; prg_sync_in = 1'b1;
        repeat (cycles) @(negedge clk);
        #1 prg_sync_in = 1'b0; selector = 2'd3; reprogram_value = 4'd0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 sys_reset = 1'b1;
        live = 1'b1;

        rd(2'd0, 6, "rst_base");
        rd(2'd1, 3, "rst_ext");
        rd(2'd2, 2, "rst_yel");
        rd(2'd3, 6, "rst_alias");

        wr(2'd1, 4'b1010, 1);
        rd(2'd1, 10, "wr_ext");
        rd(2'd0, 6, "wr_ext_base");
        rd(2'd2, 2, "wr_ext_yel");

        // Asynchronous reset with no clock edge in between.
        @(negedge clk); #1;
        interval_address = 2'd1;
        #1 sys_reset = 1'b0;
        #1 check("rst_async", output_value, 3);
        @(negedge clk); #1 sys_reset = 1'b1;
        rd(2'd1, 3, "rst_release");

        wr(2'd3, 4'd5, 1);
        wr(2'd0, 4'd0, 1);
        rd(2'd0, 6, "noop_base");
        rd(2'd1, 3, "noop_ext");
        rd(2'd2, 2, "noop_yel");

        // Held strobe with same-cycle read of the written interval.
        @(negedge clk); #1;
        interval_address = 2'd2;
        selector = 2'd2; reprogram_value = 4'd15; prg_sync_in = 1'b1;
        #1 check("hold_pre", output_value, 2);
        @(posedge clk); #1 check("hold_post", output_value, 15);
        repeat (2) @(posedge clk);
        @(negedge clk); #1 prg_sync_in = 1'b0; selector = 2'd3; reprogram_value = 4'd0;
        rd(2'd2, 15, "hold_final");
        rd(2'd0, 6, "hold_base");
        rd(2'd1, 3, "hold_ext");

        // Strobe during reset is ignored.
        @(negedge clk); #1;
        sys_reset = 1'b0;
        selector = 2'd0; reprogram_value = 4'd9; prg_sync_in = 1'b1;
        interval_address = 2'd0;
        #1 check("rst_hold", output_value, 6);
        repeat (2) @(negedge clk);
        #1 prg_sync_in = 1'b0; selector = 2'd3; reprogram_value = 4'd0;
        sys_reset = 1'b1;
        rd(2'd0, 6, "rst_wr_ignored");
        rd(2'd2, 2, "rst_wr_yel");

        wr(2'd0, 4'd1, 1);
        rd(2'd0, 1, "wr_base_min");
        rd(2'd3, 1, "wr_base_alias");
        rd(2'd1, 3, "wr_base_ext");

        @(negedge clk);
        live = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
